inverse_checker: RTL and testbench
==================================

INVERSE_CHECKER -- requirements
Module: inverse_checker

Interface
REQ-001 SHALL provide port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide port: x  input  4  operand register value from the additive-inverse processor.
REQ-004 SHALL provide port: y  input  4  claimed additive inverse from the processor.
REQ-005 SHALL provide port: zero  input  1  processor completion flag; a rising edge requests a check.
REQ-006 SHALL provide port: busy  output  1  high while a check is in progress (states ADD, REPORT).
REQ-007 SHALL provide port: done  output  1  one-cycle pulse marking a finished check.
REQ-008 SHALL provide port: ok  output  1  result of the last check (1 = x+y mod 16 is 0); held until the next report.
REQ-009 SHALL provide port: pass_count  output  8  number of passing checks, saturating.
REQ-010 SHALL provide port: fail_count  output  8  number of failing checks, saturating.

Function
REQ-011 SHALL use a three-state FSM: IDLE, ADD, REPORT.
REQ-012 SHALL register zero into zero_q every cycle; a start event is zero=1 and zero_q=0.
REQ-013 In IDLE, a start event SHALL load acc<=x and cnt<=y and move to ADD on the same edge.
REQ-014 A start event outside IDLE SHALL be ignored, with no queuing.
REQ-015 In ADD with cnt!=0, the block SHALL set acc<=acc+1 mod 16 and cnt<=cnt-1.
REQ-016 In ADD with cnt==0, the block SHALL register ok<=(acc==0), update one counter, and move to REPORT.
REQ-017 In REPORT, the block SHALL drive done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency SHALL be y+2 cycles, from the edge sampling the start event to the first cycle with done=1.
REQ-019 pass_count (ok=1) or fail_count (ok=0) SHALL increment by one per check and stop at 255.
REQ-020 ok, pass_count and fail_count SHALL be valid in the same cycle done is high.
REQ-021 acc and cnt SHALL be 4-bit; all arithmetic SHALL wrap modulo 16 without carry-out.
REQ-022 busy SHALL be a combinational decode of state (state != IDLE); done SHALL be a Moore decode of REPORT.
REQ-023 Input values after the load edge SHALL NOT affect an in-progress check.

Reset
REQ-024 While reset=1, the block SHALL force state=IDLE, acc=0, cnt=0, ok=0, pass_count=0, fail_count=0, busy=0, done=0.
REQ-025 Reset SHALL force zero_q=1, so a zero already high when reset drops is not a start event.
REQ-026 Reset asserted mid-ADD or mid-REPORT SHALL abort the check with no counter update and no done pulse.
REQ-027 Reset SHALL take priority over any simultaneous start event.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=2'b00, ADD=2'b01, REPORT=2'b10), DATA_W=4 and CNT_W=8.
REQ-029 The design SHALL split into a controller sub-module, inverse_checker_fsm, and a top-level datapath.
REQ-030 inverse_checker_fsm SHALL own the state and zero_q and drive load, step and report strobes.
REQ-031 The top-level datapath SHALL own acc, cnt, ok and the two counters.

Verification
REQ-032 Bench SHALL apply x=3, y=13 with a zero rising edge and check done after 15 cycles, ok=1, pass_count=1.
REQ-033 Bench SHALL apply x=3, y=12 with a zero rising edge and check done after 14 cycles, ok=0, fail_count=1.
REQ-034 Bench SHALL apply x=0, y=0 with a zero rising edge and check done after 2 cycles, ok=1, busy high for exactly 2 cycles.
REQ-035 Bench SHALL apply x=1, y=15, then a second zero edge during ADD, and check exactly one done pulse and pass_count=1.
REQ-036 Bench SHALL run 260 passing checks and check pass_count=255 with fail_count=0.
REQ-037 Bench SHALL apply x=5, y=11 and assert reset 4 cycles into ADD, and check no done pulse, all counters 0, state IDLE.
REQ-038 Bench SHALL hold zero high across reset release and check no start event.

Source files
------------

// File: rtl/inverse_checker_pkg.sv
// inverse_checker_pkg: shared state encoding, widths and saturating increment
package inverse_checker_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ADD = 2'b01, REPORT = 2'b10} state_t;
  localparam int DATA_W = 4;
  localparam int CNT_W = 8;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/inverse_checker_fsm.sv
// inverse_checker_fsm: start-edge detect and IDLE/ADD/REPORT sequencing with load/step/report strobes
module inverse_checker_fsm
  import inverse_checker_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic zero,
  input  logic cnt_zero,
  output logic load,
  output logic step,
  output logic report,
  output logic busy,
  output logic done
);
  state_t state, state_next;
  logic zero_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      zero_q <= 1'b1;
    end else begin
      state  <= state_next;
      zero_q <= zero;
    end
  end
  always_comb begin
    load       = (state == IDLE) && zero && !zero_q;
    step       = (state == ADD) && !cnt_zero;
    report     = (state == ADD) && cnt_zero;
    state_next = load ? ADD : report ? REPORT : (state == ADD) ? ADD : IDLE;
    busy       = state != IDLE;
    done       = state == REPORT;
  end
endmodule

// File: rtl/inverse_checker.sv
// inverse_checker: verifies x+y wraps to zero by counting y increments onto x, tallying pass/fail
module inverse_checker
  import inverse_checker_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              zero,
  output logic              busy,
  output logic              done,
  output logic              ok,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count
);
  logic [DATA_W-1:0] acc, cnt;
  logic load, step, report, cnt_zero;
  assign cnt_zero = cnt == '0;
  inverse_checker_fsm u_fsm (
    .clk(clk),
    .reset(reset),
    .zero(zero),
    .cnt_zero(cnt_zero),
    .load(load),
    .step(step),
    .report(report),
    .busy(busy),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      ok         <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else if (load) begin
      acc <= x;
      cnt <= y;
    end else if (step) begin
      acc <= acc + 1'b1;
      cnt <= cnt - 1'b1;
    end else if (report) begin
      ok <= acc == '0;
      if (acc == '0) pass_count <= sat_inc(pass_count);
      else fail_count <= sat_inc(fail_count);
    end
  end
endmodule

// File: tb/tb_inverse_checker.sv
// tb_inverse_checker: directed and randomized checks of inverse_checker against an arithmetic reference model
module tb_inverse_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic zero = 1'b0;
  logic busy, done, ok;
  logic [7:0] pass_count, fail_count;
  int checks = 0;
  int failures = 0;
  int pass_m = 0;
  int fail_m = 0;
  int ok_m = 0;
  always #5 clk = ~clk;
  inverse_checker dut (
    .clk(clk),
    .reset(reset),
    .x(x),
    .y(y),
    .zero(zero),
    .busy(busy),
    .done(done),
    .ok(ok),
    .pass_count(pass_count),
    .fail_count(fail_count)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_check(input logic [3:0] xv, input logic [3:0] yv, input bit glitch);
    int n, busy_n, dones;
    bit got;
    zero = 1'b0;
    tick();
    x = xv;
    y = yv;
    zero = 1'b1;
    tick();
    n = 1;
    busy_n = 0;
    dones = 0;
    got = 0;
    x = 4'($urandom);
    y = 4'($urandom);
    while (!got && n <= 40) begin
      if (busy) busy_n++;
      if (done) begin
        got = 1;
        dones++;
      end else begin
        if (glitch && n == 3) zero = 1'b0;
        if (glitch && n == 4) zero = 1'b1;
        tick();
        n++;
      end
    end
    ok_m = ((int'(xv) + int'(yv)) % 16 == 0) ? 1 : 0;
    if (ok_m == 1) pass_m = (pass_m < 255) ? pass_m + 1 : 255;
    else fail_m = (fail_m < 255) ? fail_m + 1 : 255;
    chk("latency", got ? n : -1, int'(yv) + 2);
    chk("ok", int'(ok), ok_m);
    chk("pass_count", int'(pass_count), pass_m);
    chk("fail_count", int'(fail_count), fail_m);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
      if (busy) busy_n++;
    end
    chk("busy_cycles", busy_n, int'(yv) + 2);
    chk("done_pulses", dones, 1);
  endtask
  initial begin
    zero = 1'b1;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ok", int'(ok), 0);
    chk("rst_pass", int'(pass_count), 0);
    chk("rst_fail", int'(fail_count), 0);
    reset = 1'b0;
    begin
      int b = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (busy || done) b++;
      end
      chk("zero_held_no_start", b, 0);
    end
    run_check(4'd3, 4'd13, 1'b0);
    run_check(4'd3, 4'd12, 1'b0);
    run_check(4'd0, 4'd0, 1'b0);
    run_check(4'd1, 4'd15, 1'b1);
    for (int i = 0; i < 20; i++) begin
      logic [3:0] xr, yr;
      xr = 4'($urandom);
      yr = ($urandom_range(0, 1) == 1) ? 4'(16 - int'(xr)) : 4'($urandom);
      run_check(xr, yr, 1'b0);
    end
    zero = 1'b0;
    tick();
    x = 4'd5;
    y = 4'd11;
    zero = 1'b1;
    tick();
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    pass_m = 0;
    fail_m = 0;
    begin
      int d = 0, b = 0;
      for (int i = 0; i < 20; i++) begin
        if (done) d++;
        if (busy) b++;
        tick();
      end
      chk("abort_done", d, 0);
      chk("abort_busy", b, 0);
    end
    chk("abort_pass", int'(pass_count), 0);
    chk("abort_fail", int'(fail_count), 0);
    chk("abort_ok", int'(ok), 0);
    for (int i = 0; i < 260; i++) begin
      logic [3:0] xr;
      xr = 4'($urandom_range(0, 6));
      run_check(xr, 4'(16 - int'(xr)), 1'b0);
    end
    chk("sat_pass", int'(pass_count), 255);
    chk("sat_fail", int'(fail_count), 0);
    for (int i = 0; i < 5; i++) run_check(4'($urandom), 4'($urandom), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
